pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter AW, default 32: PC and datapath width; AW SHALL be >= 32.
REQ-002 Parameter RESET_PC, default 32'h0000_3000: F_pc value after reset.
REQ-003 Parameter EXC_VEC, default 32'h0000_4180: exception entry address.
REQ-004 Parameters IM_LO / IM_HI, defaults 32'h0000_3000 / 32'h0000_6FFC: legal fetch range, inclusive.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hazard stall; F/D frozen.
REQ-008 req  in  1  exception/interrupt request from CP0.
REQ-009 eret  in  1  eret resolved; return to epc.
REQ-010 epc  in  AW  return address.
REQ-011 D_pc  in  AW  PC of the D-stage instruction.
REQ-012 imm16 / addr26  in  16 / 26  branch offset / jump index.
REQ-013 ra_data, D_V1, D_V2  in  AW  forwarded register values for jr / jabs.
REQ-014 branch  in  1; jump  in  2 (01 j/jal, 10 jr); jabs  in  1.
REQ-015 F_pc  out  AW  registered fetch PC.
REQ-016 F_adel  out  1  fetch address error for current F_pc.
REQ-017 pend  out  1  eret redirect buffered.

Function
REQ-018 Next PC priority: req > eret-or-pending > jabs > jump > branch > F_pc+4.
REQ-019 req SHALL load F_pc=EXC_VEC at next edge regardless of stall, and clear pend.
REQ-020 eret with stall=0 and req=0 SHALL load F_pc=epc at next edge.
REQ-021 eret with stall=1 and req=0 SHALL set pend, latch epc into pend_target; F_pc holds.
REQ-022 With pend=1, stall=0 and req=0, F_pc SHALL load pend_target and pend SHALL clear in the same edge.
REQ-023 New eret while pend=1 SHALL overwrite pend_target.
REQ-024 stall=1 without req SHALL hold F_pc; branch/jump/jabs are ignored.
REQ-025 Branch target = D_pc+4 + (sext(imm16)<<2), modulo 2^AW.
REQ-026 jump=01 target = {(D_pc+4)[AW-1:28], addr26, 2'b00}; jump=10 target = ra_data; jump=11 is treated as 00.
REQ-027 jabs target = branch target + |(D_V1-D_V2)<<2|; the difference and shift are truncated to AW bits first, and the absolute value is two's-complement.
REQ-028 F_adel SHALL be combinational: 1 iff F_pc[1:0]!=0, F_pc<IM_LO or F_pc>IM_HI.
REQ-029 Misaligned targets SHALL still be loaded; the error is reported only via F_adel.

Reset
REQ-030 reset SHALL force F_pc=RESET_PC, pend=0 and pend_target=0 immediately, independent of clk.
REQ-031 Reset mid-stall or with pend=1 SHALL discard the buffered redirect.

Configuration
REQ-032 Macro PC_UNIT_JABS_EN defined: jabs handled per REQ-027.
REQ-033 Macro PC_UNIT_JABS_EN undefined: jabs input ignored and no jabs logic synthesised; all other behaviour unchanged.

Verification
REQ-034 Reset, then 3 free cycles -> F_pc 0x3000, 0x3004, 0x3008, 0x300C; F_adel=0.
REQ-035 D_pc=0x3008, imm16=0xFFFE, branch=1 -> next F_pc=0x3004.
REQ-036 Macro on: D_pc=0x3000, imm16=0x0001, D_V1=1, D_V2=5, jabs=1 -> next F_pc=0x3018. Macro off, same stimulus -> F_pc+4.
REQ-037 stall=1 for 3 cycles, eret=1 epc=0x3100 in the first -> F_pc held, pend=1; the edge after stall drops gives F_pc=0x3100, pend=0.
REQ-038 req=1, eret=1, branch=1 in the same cycle with pend=1 -> F_pc=0x4180, pend=0.
REQ-039 jump=10, ra_data=0x3002 -> F_pc=0x3002, F_adel=1; jump=10, ra_data=0x7000 -> F_adel=1.

Source files
------------

// File: rtl/pc_unit_if.sv
// Signal bundle between the pipeline control and the fetch PC unit.
// master drives redirect/hazard controls; slave (pc_unit) returns the fetch PC status.
interface pc_unit_if #(
  parameter int unsigned AW = 32
);
  logic          stall;
  logic          req;
  logic          eret;
  logic [AW-1:0] epc;
  logic [AW-1:0] D_pc;
  logic [15:0]   imm16;
  logic [25:0]   addr26;
  logic [AW-1:0] ra_data;
  logic [AW-1:0] D_V1;
  logic [AW-1:0] D_V2;
  logic          branch;
  logic [1:0]    jump;
  logic          jabs;
  logic [AW-1:0] F_pc;
  logic          F_adel;
  logic          pend;

  modport master (
    output stall, req, eret, epc, D_pc, imm16, addr26, ra_data, D_V1, D_V2,
           branch, jump, jabs,
    input  F_pc, F_adel, pend
  );

  modport slave (
    input  stall, req, eret, epc, D_pc, imm16, addr26, ra_data, D_V1, D_V2,
           branch, jump, jabs,
    output F_pc, F_adel, pend
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with exception/eret redirect, buffered eret under stall, and branch/jump
// targets. Define PC_UNIT_JABS_EN to add the jabs (branch + |(V1-V2)<<2|) redirect. AW >= 32.
module pc_unit #(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_3000),
  parameter logic [AW-1:0] EXC_VEC  = AW'(32'h0000_4180),
  parameter logic [AW-1:0] IM_LO    = AW'(32'h0000_3000),
  parameter logic [AW-1:0] IM_HI    = AW'(32'h0000_6FFC)
) (
  input logic       clk,
  input logic       reset,
  pc_unit_if.slave  bus
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] tgt_q, tgt_d;
  logic          pend_q, pend_d;

  logic [AW-1:0] seq_pc;
  logic [AW-1:0] d_pc4;
  logic [AW-1:0] br_off;
  logic [AW-1:0] br_tgt;
  logic [AW-1:0] j_tgt;
  logic [AW-1:0] ctl_tgt;
  logic          jabs_hit;
  logic [AW-1:0] jabs_tgt;

  assign seq_pc = pc_q + AW'(4);
  assign d_pc4  = bus.D_pc + AW'(4);
  assign br_off = {{(AW-18){bus.imm16[15]}}, bus.imm16, 2'b00};
  assign br_tgt = d_pc4 + br_off;
  assign j_tgt  = {d_pc4[AW-1:28], bus.addr26, 2'b00};

`ifdef PC_UNIT_JABS_EN
  logic [AW-1:0] diff_sh;
  logic [AW-1:0] abs_sh;

  // Difference and shift wrap at AW bits before the absolute value is taken.
  assign diff_sh  = (bus.D_V1 - bus.D_V2) << 2;
  assign abs_sh   = diff_sh[AW-1] ? (AW'(0) - diff_sh) : diff_sh;
  assign jabs_tgt = br_tgt + abs_sh;
  assign jabs_hit = bus.jabs;
`else
  logic unused_jabs;

  assign unused_jabs = ^{bus.jabs, bus.D_V1, bus.D_V2};
  assign jabs_tgt    = '0;
  assign jabs_hit    = 1'b0;
`endif

  // Control-flow target from the D-stage instruction; jump=11 falls through like 00.
  always_comb begin
    ctl_tgt = seq_pc;
    if (jabs_hit) begin
      ctl_tgt = jabs_tgt;
    end else if (bus.jump == 2'b01) begin
      ctl_tgt = j_tgt;
    end else if (bus.jump == 2'b10) begin
      ctl_tgt = bus.ra_data;
    end else if (bus.branch) begin
      ctl_tgt = br_tgt;
    end
  end

  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    tgt_d  = tgt_q;
    if (bus.req) begin
      pc_d   = EXC_VEC;
      pend_d = 1'b0;
    end else if (bus.stall) begin
      // Park the eret target until the stall releases; a newer eret overwrites it.
      if (bus.eret) begin
        pend_d = 1'b1;
        tgt_d  = bus.epc;
      end
    end else if (bus.eret) begin
      pc_d   = bus.epc;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = tgt_q;
      pend_d = 1'b0;
    end else begin
      pc_d = ctl_tgt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

  assign bus.F_pc   = pc_q;
  assign bus.pend   = pend_q;
  assign bus.F_adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: directed cases plus random stimulus against a reference model.
module tb_pc_unit;
  localparam int unsigned AW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFC;

  logic clk = 1'b0;
  logic reset;

  pc_unit_if #(.AW(AW)) bus ();

  pc_unit #(
    .AW      (AW),
    .RESET_PC(RESET_PC),
    .EXC_VEC (EXC_VEC),
    .IM_LO   (IM_LO),
    .IM_HI   (IM_HI)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] d_pc;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] ra;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        branch;
    logic [1:0]  jump;
    logic        jabs;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic        adel;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endfunction

  function automatic logic model_adel(logic [31:0] pc);
    return (pc % 4 != 0) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

  function automatic logic [31:0] model_target(stim_t s);
    int          off;
    int          d;
    int          a;
    logic [31:0] dp4;
    logic [31:0] bt;
    dp4 = s.d_pc + 32'd4;
    off = int'($signed(s.imm16)) * 4;
    bt  = dp4 + 32'(off);
`ifdef PC_UNIT_JABS_EN
    if (s.jabs) begin
      d = int'(s.v1 - s.v2) * 4;
      a = (d < 0) ? -d : d;
      return bt + 32'(a);
    end
`else
    d = 0;
    a = d;
`endif
    if (s.jump == 2'd1) return (dp4 & 32'hF000_0000) | (32'(s.addr26) * 4);
    if (s.jump == 2'd2) return s.ra;
    if (s.branch) return bt;
    return m_pc + 32'd4;
  endfunction

  function automatic void model_step(stim_t s);
    logic [31:0] nxt;
    nxt = model_target(s);
    if (s.req) begin
      m_pc   = EXC_VEC;
      m_pend = 1'b0;
    end else if (s.stall) begin
      if (s.eret) begin
        m_pend = 1'b1;
        m_tgt  = s.epc;
      end
    end else if (s.eret) begin
      m_pc   = s.epc;
      m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc   = m_tgt;
      m_pend = 1'b0;
    end else begin
      m_pc = nxt;
    end
  endfunction

  function automatic void model_reset();
    m_pc   = RESET_PC;
    m_pend = 1'b0;
    m_tgt  = 32'd0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{stall: 1'b0, req: 1'b0, eret: 1'b0, epc: 32'd0, d_pc: 32'd0, imm16: 16'd0,
          addr26: 26'd0, ra: 32'd0, v1: 32'd0, v2: 32'd0, branch: 1'b0, jump: 2'd0,
          jabs: 1'b0};
    return s;
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return 32'h3000 + ($urandom_range(0, 32'h0FFF) * 4);
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.stall  = ($urandom_range(0, 3) == 0);
    s.req    = ($urandom_range(0, 19) == 0);
    s.eret   = ($urandom_range(0, 9) == 0);
    s.epc    = rand_addr();
    s.d_pc   = rand_addr();
    s.imm16  = 16'($urandom);
    s.addr26 = 26'($urandom);
    s.ra     = rand_addr();
    s.v1     = $urandom;
    s.v2     = $urandom;
    s.branch = 1'($urandom_range(0, 1));
    s.jump   = 2'($urandom_range(0, 3));
    s.jabs   = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.stall   = s.stall;
    bus.req     = s.req;
    bus.eret    = s.eret;
    bus.epc     = s.epc;
    bus.D_pc    = s.d_pc;
    bus.imm16   = s.imm16;
    bus.addr26  = s.addr26;
    bus.ra_data = s.ra;
    bus.D_V1    = s.v1;
    bus.D_V2    = s.v2;
    bus.branch  = s.branch;
    bus.jump    = s.jump;
    bus.jabs    = s.jabs;
  endtask

  task automatic push_now();
    exp_t e;
    e.pc   = m_pc;
    e.pend = m_pend;
    e.adel = model_adel(m_pc);
    sb_q.push_back(e);
  endtask

  // Apply one cycle of stimulus; the expected post-edge state goes to the scoreboard.
  task automatic drive(input stim_t s);
    apply(s);
    model_step(s);
    push_now();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #2;
    end
    chk("sb_drain_left", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_F_pc", bus.F_pc, mon_e.pc);
        chk("sb_pend", 32'(bus.pend), 32'(mon_e.pend));
        chk("sb_F_adel", 32'(bus.F_adel), 32'(mon_e.adel));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [31:0] held;

    reset = 1'b1;
    apply(idle());
    model_reset();
    #1;
    chk("reset_async_pc", bus.F_pc, RESET_PC);
    chk("reset_async_pend", 32'(bus.pend), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    push_now();

    // Free-running fetch
    repeat (3) drive(idle());
    chk("free_run_pc", bus.F_pc, 32'h300C);
    chk("free_run_adel", 32'(bus.F_adel), 32'd0);

    // Backward branch
    s = idle(); s.d_pc = 32'h3008; s.imm16 = 16'hFFFE; s.branch = 1'b1;
    drive(s);
    chk("branch_back_pc", bus.F_pc, 32'h3004);

    // jabs: taken only when the feature is built in
    s = idle(); s.d_pc = 32'h3000; s.imm16 = 16'h0001; s.v1 = 32'd1; s.v2 = 32'd5;
    s.jabs = 1'b1;
    drive(s);
`ifdef PC_UNIT_JABS_EN
    chk("jabs_pc", bus.F_pc, 32'h3018);
`else
    chk("jabs_off_pc", bus.F_pc, 32'h3008);
`endif

    // eret under a 3-cycle stall is buffered and released when the stall drops
    held = m_pc;
    s = idle(); s.stall = 1'b1; s.eret = 1'b1; s.epc = 32'h3100;
    drive(s);
    s = idle(); s.stall = 1'b1; s.branch = 1'b1; s.jump = 2'd2; s.ra = 32'h5000;
    drive(s);
    drive(s);
    chk("stall_hold_pc", bus.F_pc, held);
    chk("stall_pend", 32'(bus.pend), 32'd1);
    drive(idle());
    chk("pend_release_pc", bus.F_pc, 32'h3100);
    chk("pend_release_clr", 32'(bus.pend), 32'd0);

    // req beats eret, branch and a pending redirect
    s = idle(); s.stall = 1'b1; s.eret = 1'b1; s.epc = 32'h3200;
    drive(s);
    s = idle(); s.stall = 1'b1; s.eret = 1'b1; s.epc = 32'h3300;
    drive(s);
    s = idle(); s.req = 1'b1; s.eret = 1'b1; s.epc = 32'h3400; s.branch = 1'b1;
    s.d_pc = 32'h3000; s.imm16 = 16'h0010;
    drive(s);
    chk("req_prio_pc", bus.F_pc, EXC_VEC);
    chk("req_prio_pend", 32'(bus.pend), 32'd0);

    // jr targets around the legal fetch window, including a misaligned one
    s = idle(); s.jump = 2'd2; s.ra = 32'h3002;
    drive(s);
    chk("jr_misalign_pc", bus.F_pc, 32'h3002);
    chk("jr_misalign_adel", 32'(bus.F_adel), 32'd1);
    s.ra = 32'h7000;
    drive(s);
    chk("jr_above_adel", 32'(bus.F_adel), 32'd1);
    s.ra = 32'h6FFC; drive(s);
    s.ra = 32'h2FFC; drive(s);
    s.ra = 32'h3000; drive(s);

    // j and jump=11 fall-through
    s = idle(); s.jump = 2'd1; s.d_pc = 32'h3000; s.addr26 = 26'h0000C40;
    drive(s);
    chk("j_pc", bus.F_pc, 32'h3100);
    s = idle(); s.jump = 2'd3; s.ra = 32'h5000;
    drive(s);
    chk("jump11_seq_pc", bus.F_pc, 32'h3104);

    // Asynchronous reset while an eret is buffered
    s = idle(); s.stall = 1'b1; s.eret = 1'b1; s.epc = 32'h3200;
    drive(s);
    drain();
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("mid_reset_pc", bus.F_pc, RESET_PC);
    chk("mid_reset_pend", 32'(bus.pend), 32'd0);
    model_reset();
    apply(idle());
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    push_now();
    drive(idle());
    chk("post_reset_no_redirect", bus.F_pc, 32'h3004);

    // Random traffic
    for (int n = 0; n < 600; n++) drive(rand_stim());
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
